instr_fetch_unit: RTL and testbench

// - Responder side of the PC/instruction-memory interface: accepts fetch addresses from the program

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 100 ++++++++++
 tb/tb_instr_fetch_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_WIDTH       = 32;
  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned MEM_ADDR_BITS    = 12;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;

  localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fault;
  } fetch_entry_t;

  typedef enum logic {
    IDLE,
    WAIT
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// PC request, ROM and decode-side signals of the fetch unit; slave = fetch unit, master = its environment.
interface instr_fetch_unit_if;

  logic                                 req_valid;
  logic [fetch_pkg::ADDR_WIDTH-1:0]     req_addr;
  logic                                 req_ready;
  logic                                 flush;
  logic                                 mem_rd_en;
  logic [fetch_pkg::MEM_ADDR_BITS-1:0]  mem_addr;
  logic [fetch_pkg::DATA_WIDTH-1:0]     mem_rdata;
  logic                                 instr_valid;
  logic [fetch_pkg::DATA_WIDTH-1:0]     instr;
  logic [fetch_pkg::ADDR_WIDTH-1:0]     instr_pc;
  logic                                 instr_fault;
  logic                                 instr_ready;

  modport slave (
    input  req_valid, req_addr, flush, mem_rdata, instr_ready,
    output req_ready, mem_rd_en, mem_addr, instr_valid, instr, instr_pc, instr_fault
  );

  modport master (
    output req_valid, req_addr, flush, mem_rdata, instr_ready,
    input  req_ready, mem_rd_en, mem_addr, instr_valid, instr, instr_pc, instr_fault
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear; head reads straight from the storage registers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pop_ok;

  // A pop on an empty FIFO is ignored.
  assign pop_ok = pop_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: accepts PC requests, reads the 1-cycle instruction ROM and queues {instr, pc} for decode.
// Define FETCH_FAULT_EN to flag misaligned / out-of-ROM fetches as NOP fault entries instead of reading.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = RESET_VECTOR,
  parameter int unsigned           FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pend_pc_q;
  logic                  pend_fault_q;

  logic [CNT_W-1:0]      fifo_count;
  fetch_entry_t          fifo_head;
  fetch_entry_t          rsp_entry;
  fetch_entry_t          head_entry;
  logic                  inflight;
  logic                  fifo_empty;
  logic                  req_ready_c;
  logic                  accept;
  logic                  fetch_fault;
  logic                  out_valid;
  logic                  fifo_push;
  logic                  fifo_pop;

`ifdef FETCH_FAULT_EN
  logic [ADDR_WIDTH-1:0] offset;

  // Below-base addresses wrap to a large offset, so one upper-bits test covers both range ends.
  assign offset        = bus.req_addr - BASE_ADDR;
  assign fetch_fault   = (offset[1:0] != 2'b00) || (offset[ADDR_WIDTH-1:MEM_ADDR_BITS+2] != '0);
  assign bus.mem_addr  = offset[MEM_ADDR_BITS+1:2];
`else
  assign fetch_fault   = 1'b0;
  assign bus.mem_addr  = MEM_ADDR_BITS'((bus.req_addr - BASE_ADDR) >> 2);
`endif

  // Outstanding work = buffered entries plus the one read in flight; never overcommit the FIFO.
  assign inflight    = (state_q == WAIT);
  assign fifo_empty  = (fifo_count == '0);
  assign req_ready_c = ~bus.flush &
                       ((SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));
  assign accept      = bus.req_valid & req_ready_c;

  assign bus.req_ready = req_ready_c;
  assign bus.mem_rd_en = accept & ~bus.flush & ~fetch_fault;

  always_comb begin
    rsp_entry.instr = pend_fault_q ? NOP_INSTR : bus.mem_rdata;
    rsp_entry.pc    = pend_pc_q;
    rsp_entry.fault = pend_fault_q;
  end

  // The ROM response falls through to the head when nothing older is buffered.
  assign head_entry = fifo_empty ? rsp_entry : fifo_head;
  assign out_valid  = ~fifo_empty | inflight;
  assign fifo_pop   = bus.instr_ready & ~fifo_empty;
  assign fifo_push  = inflight & ~bus.flush & ~(fifo_empty & bus.instr_ready);

  assign bus.instr_valid = out_valid;
  assign bus.instr       = out_valid ? head_entry.instr : '0;
  assign bus.instr_pc    = out_valid ? head_entry.pc    : '0;
  assign bus.instr_fault = out_valid & head_entry.fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_pc_q    <= '0;
      pend_fault_q <= 1'b0;
    end else if (accept) begin
      state_q      <= WAIT;
      pend_pc_q    <= bus.req_addr;
      pend_fault_q <= fetch_fault;
    end else begin
      state_q      <= IDLE;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (bus.flush),
    .push_i      (fifo_push),
    .push_data_i (rsp_entry),
    .pop_i       (fifo_pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised and directed bench for instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned ROM_WORDS = 4096;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] BASE      = 32'hBFC0_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic clk;
  logic rst;
  logic [31:0] rom [ROM_WORDS];
  exp_t exp_q[$];
  int n_checks;
  int n_errors;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= rom[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_fault(input logic [31:0] a);
`ifdef FETCH_FAULT_EN
    return (a % 4 != 0) || (a < BASE) || (a >= BASE + 32'(4 * ROM_WORDS));
`else
    return (a === 32'hx);
`endif
  endfunction

  function automatic logic [11:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - BASE) / 4) % ROM_WORDS;
    return w[11:0];
  endfunction

  function automatic logic [31:0] ref_instr(input logic [31:0] a);
    if (ref_fault(a)) return 32'h0000_0013;
    return rom[ref_word(a)];
  endfunction

  // One clock: drive at negedge, check outputs against the model, then advance the model at posedge.
  task automatic step(input logic v, input logic [31:0] a, input logic fl, input logic rdy,
                      output bit acc);
    bit exp_ready, exp_valid, exp_rd;
    @(negedge clk);
    bus.req_valid   = v;
    bus.req_addr    = a;
    bus.flush       = fl;
    bus.instr_ready = rdy;
    #1;
    exp_ready = !fl && (exp_q.size() < DEPTH);
    exp_valid = exp_q.size() > 0;
    exp_rd    = v && exp_ready && !ref_fault(a);
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
    check("mem_rd_en", 32'(bus.mem_rd_en), 32'(exp_rd));
    if (exp_rd) check("mem_addr", 32'(bus.mem_addr), 32'(ref_word(a)));
    if (exp_valid) begin
      check("instr", bus.instr, exp_q[0].instr);
      check("instr_pc", bus.instr_pc, exp_q[0].pc);
      check("instr_fault", 32'(bus.instr_fault), 32'(exp_q[0].fault));
    end
    @(posedge clk);
    acc = v && exp_ready;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rdy) void'(exp_q.pop_front());
      if (acc) exp_q.push_back('{instr: ref_instr(a), pc: a, fault: ref_fault(a)});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_pc", bus.instr_pc, 32'd0);
    check("rst_fault", 32'(bus.instr_fault), 32'd0);
  endtask

  initial begin
    bit acc;
    logic [31:0] pc;
    logic [31:0] a;
    clk             = 1'b0;
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.mem_rdata   = '0;
    n_checks        = 0;
    n_errors        = 0;
    for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] = $urandom;
    rom[0] = 32'h0050_0093;

    do_reset();

    // Reset vector fetch, one-cycle latency.
    step(1'b1, BASE, 1'b0, 1'b1, acc);
    #1;
    check("vec_valid", 32'(bus.instr_valid), 32'd1);
    check("vec_instr", bus.instr, 32'h0050_0093);
    check("vec_pc", bus.instr_pc, BASE);

    // Back-to-back streaming with decode always ready.
    for (int k = 0; k < 4; k++) step(1'b1, BASE + 32'(4 * k), 1'b0, 1'b1, acc);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, acc);

    // Backpressure: FIFO fills, then one pop reopens the request port.
    for (int k = 0; k < 4; k++) step(1'b1, BASE + 32'h100 + 32'(4 * k), 1'b0, 1'b0, acc);
    for (int k = 0; k < 4; k++) step(1'b1, BASE + 32'h200 + 32'(4 * k), 1'b0, 1'b1, acc);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, acc);

    // Flush with one buffered entry and one read in flight, then redirect.
    step(1'b1, BASE + 32'h300, 1'b0, 1'b0, acc);
    step(1'b1, BASE + 32'h304, 1'b0, 1'b0, acc);
    step(1'b1, BASE + 32'h308, 1'b1, 1'b0, acc);
    #1;
    check("flush_valid", 32'(bus.instr_valid), 32'd0);
    step(1'b1, BASE + 32'h40, 1'b0, 1'b0, acc);
    #1;
    check("redirect_instr", bus.instr, rom[16]);
    check("redirect_pc", bus.instr_pc, BASE + 32'h40);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, acc);

`ifdef FETCH_FAULT_EN
    step(1'b1, BASE + 32'h2, 1'b0, 1'b1, acc);
    #1;
    check("fault_flag", 32'(bus.instr_fault), 32'd1);
    check("fault_nop", bus.instr, 32'h0000_0013);
    step(1'b1, BASE - 32'h4, 1'b0, 1'b1, acc);
    step(1'b1, BASE + 32'(4 * ROM_WORDS), 1'b0, 1'b1, acc);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, acc);
`endif

    // Reset while a read is in flight and the FIFO holds an entry.
    step(1'b1, BASE + 32'h8, 1'b0, 1'b0, acc);
    step(1'b1, BASE + 32'hC, 1'b0, 1'b0, acc);
    do_reset();
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, acc);

    // Randomised traffic with sequential PCs, jumps, flushes and decode stalls.
    pc = BASE;
    for (int n = 0; n < 600; n++) begin
      a = pc;
      if ($urandom_range(0, 7) == 0) a = BASE + (($urandom_range(0, ROM_WORDS - 1)) << 2);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      step(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0), acc);
      if (acc) pc = a + 32'd4;
    end
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
